// File: rtl/comp_mult_pkg.sv
// Shared types and width helpers for the complex-multiply checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package comp_mult_pkg;

    // Checker FSM: actively comparing, or frozen after a mismatch.
    typedef enum logic {
        CHECK = 1'b0,
        HALT  = 1'b1
    } chk_state_t;

    // Width of one operand bundle {x1, y1, x2, y2}.
    function automatic int op_w(input int dw);
        return 4 * dw;
    endfunction

    // Width of one result component (xr or yr): two products summed, plus one guard bit.
    function automatic int comp_w(input int dw);
        return 2 * (dw + 1);
    endfunction

    // Width of a full result {xr, yr}.
    function automatic int res_w(input int dw);
        return 4 * (dw + 1);
    endfunction

    // Default build widths.
    localparam int DWIDTH_DEF = 8;
    localparam int OP_W_DEF   = op_w(DWIDTH_DEF);
    localparam int COMP_W_DEF = comp_w(DWIDTH_DEF);
    localparam int RES_W_DEF  = res_w(DWIDTH_DEF);

endpackage

// File: rtl/comp_mult_fifo.sv
// Circular FIFO holding operand bundles until the matching result arrives.
// Latency: rdata shows the head combinationally; a push is visible at the head the cycle after.
// Backpressure: none upstream; a push while full is dropped unless a pop happens in the same cycle.
module comp_mult_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             push_ok;
    logic             pop_ok;

    // A full queue still accepts a push when a pop frees the head slot in the same cycle.
    assign full    = (cnt == (AW + 1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop);
    assign rdata   = mem[rd_ptr];
    assign level   = cnt;

    // Pointers wrap naturally since DEPTH is a power of two; clr acts as a synchronous flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + (AW + 1)'(1);
                2'b01:   cnt <= cnt - (AW + 1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is deliberately left unreset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok && !clr) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/comp_mult_checker.sv
// Scoreboard for a complex multiplier: queues operands, recomputes the product, compares DUT results.
// Latency: chk_valid/chk_err one cycle after the result pop; counters and first_* update the cycle after that.
// Backpressure: passive observer; queue overflow and underflow are flagged, never stalled.
module comp_mult_checker
    import comp_mult_pkg::*;
#(
    parameter int DWIDTH      = 8,
    parameter int DEPTH       = 16,
    parameter int CWIDTH      = 16,
    parameter int STOP_ON_ERR = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sw_rst,
    input  logic                        op_val,
    input  logic                        op_rdy,
    input  logic [4*DWIDTH-1:0]         op_data,
    input  logic                        res_val,
    input  logic                        res_rdy,
    input  logic [4*(DWIDTH+1)-1:0]     res_data,
    output logic                        chk_valid,
    output logic                        chk_err,
    output logic [CWIDTH-1:0]           pass_cnt,
    output logic [CWIDTH-1:0]           err_cnt,
    output logic [$clog2(DEPTH):0]      q_level,
    output logic                        ovf,
    output logic                        unf,
    output logic                        halted,
    output logic [4*(DWIDTH+1)-1:0]     first_got,
    output logic [4*(DWIDTH+1)-1:0]     first_exp
);

    localparam int OPW = op_w(DWIDTH);
    localparam int CW  = comp_w(DWIDTH);
    localparam int RW  = res_w(DWIDTH);
    localparam int PW  = 2 * DWIDTH;

    chk_state_t       state;
    chk_state_t       state_nxt;

    logic             push;
    logic             pop;
    logic             pop_ok;
    logic             fifo_full;
    logic             fifo_empty;
    logic [OPW-1:0]   head;

    logic             s_vld;
    logic [OPW-1:0]   s_ops;
    logic [RW-1:0]    s_res;

    logic signed [DWIDTH-1:0] x1;
    logic signed [DWIDTH-1:0] y1;
    logic signed [DWIDTH-1:0] x2;
    logic signed [DWIDTH-1:0] y2;
    logic signed [PW-1:0]     p_xx;
    logic signed [PW-1:0]     p_yy;
    logic signed [PW-1:0]     p_xy;
    logic signed [PW-1:0]     p_yx;
    logic signed [CW-1:0]     xr_e;
    logic signed [CW-1:0]     yr_e;
    logic [RW-1:0]            exp_res;
    logic                     mismatch;
    logic                     have_first;

    assign push   = op_val & op_rdy;
    assign pop    = res_val & res_rdy;
    assign pop_ok = pop & ~fifo_empty;

    comp_mult_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (OPW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (sw_rst),
        .push  (push),
        .pop   (pop),
        .wdata (op_data),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (q_level)
    );

    // Capture the queue head and the DUT result on a successful pop; the compare happens next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_vld <= 1'b0;
            s_ops <= '0;
            s_res <= '0;
        end else if (sw_rst) begin
            s_vld <= 1'b0;
        end else begin
            s_vld <= pop_ok;
            if (pop_ok) begin
                s_ops <= head;
                s_res <= res_data;
            end
        end
    end

    // Reference product: full-width signed products, so the result is exact for every input,
    // including (-2^(D-1))^2 terms that need the extra guard bit.
    assign x1   = s_ops[4*DWIDTH-1 -: DWIDTH];
    assign y1   = s_ops[3*DWIDTH-1 -: DWIDTH];
    assign x2   = s_ops[2*DWIDTH-1 -: DWIDTH];
    assign y2   = s_ops[DWIDTH-1   -: DWIDTH];
    assign p_xx = PW'(x1) * PW'(x2);
    assign p_yy = PW'(y1) * PW'(y2);
    assign p_xy = PW'(x1) * PW'(y2);
    assign p_yx = PW'(y1) * PW'(x2);
    assign xr_e = CW'(p_xx) - CW'(p_yy);
    assign yr_e = CW'(p_xy) + CW'(p_yx);
    assign exp_res  = {xr_e, yr_e};
    assign mismatch = (exp_res != s_res);

    // Once halted the pipeline keeps draining but its results are no longer reported.
    assign chk_valid = s_vld & (state == CHECK);
    assign chk_err   = chk_valid & mismatch;
    assign halted    = (state == HALT);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CHECK;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: freeze on a reported mismatch when configured to stop; leave only via reset.
    always_comb begin
        state_nxt = state;
        if (sw_rst) begin
            state_nxt = CHECK;
        end else begin
            case (state)
                CHECK: begin
                    if (chk_err && (STOP_ON_ERR != 0)) begin
                        state_nxt = HALT;
                    end
                end
                HALT: begin
                    state_nxt = HALT;
                end
                default: begin
                    state_nxt = CHECK;
                end
            endcase
        end
    end

    // Saturating match/mismatch counters, stepped by each reported compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_cnt <= '0;
            err_cnt  <= '0;
        end else if (sw_rst) begin
            pass_cnt <= '0;
            err_cnt  <= '0;
        end else if (chk_valid) begin
            if (mismatch) begin
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + CWIDTH'(1);
                end
            end else begin
                if (pass_cnt != '1) begin
                    pass_cnt <= pass_cnt + CWIDTH'(1);
                end
            end
        end
    end

    // Snapshot of the first mismatch since reset; held until the next reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            have_first <= 1'b0;
            first_got  <= '0;
            first_exp  <= '0;
        end else if (sw_rst) begin
            have_first <= 1'b0;
            first_got  <= '0;
            first_exp  <= '0;
        end else if (chk_err && !have_first) begin
            have_first <= 1'b1;
            first_got  <= s_res;
            first_exp  <= exp_res;
        end
    end

    // Sticky queue-misuse flags: a dropped push, or a pop with nothing queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (sw_rst) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            ovf <= ovf | (push & fifo_full & ~pop);
            unf <= unf | (pop & fifo_empty);
        end
    end

endmodule

// File: tb/tb_comp_mult_checker.sv
// Self-checking bench for comp_mult_checker (DWIDTH=8, DEPTH=4, STOP_ON_ERR=1).
// Latency: drives inputs after the falling edge, samples 1 time unit after the rising edge.
// Backpressure: n/a.
module tb_comp_mult_checker;

    localparam int DW     = 8;
    localparam int DEPTH  = 4;
    localparam int CWIDTH = 16;
    localparam int CMAX   = 65535;

    logic        clk = 1'b0;
    logic        rst;
    logic        sw_rst;
    logic        op_val;
    logic        op_rdy;
    logic [31:0] op_data;
    logic        res_val;
    logic        res_rdy;
    logic [35:0] res_data;
    logic        chk_valid;
    logic        chk_err;
    logic [15:0] pass_cnt;
    logic [15:0] err_cnt;
    logic [2:0]  q_level;
    logic        ovf;
    logic        unf;
    logic        halted;
    logic [35:0] first_got;
    logic [35:0] first_exp;

    int tests = 0;
    int fails = 0;

    comp_mult_checker #(
        .DWIDTH      (DW),
        .DEPTH       (DEPTH),
        .CWIDTH      (CWIDTH),
        .STOP_ON_ERR (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_rst    (sw_rst),
        .op_val    (op_val),
        .op_rdy    (op_rdy),
        .op_data   (op_data),
        .res_val   (res_val),
        .res_rdy   (res_rdy),
        .res_data  (res_data),
        .chk_valid (chk_valid),
        .chk_err   (chk_err),
        .pass_cnt  (pass_cnt),
        .err_cnt   (err_cnt),
        .q_level   (q_level),
        .ovf       (ovf),
        .unf       (unf),
        .halted    (halted),
        .first_got (first_got),
        .first_exp (first_exp)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] opk(input int x1, input int y1, input int x2, input int y2);
        logic [7:0] a, b, c, d;
        a = x1[7:0]; b = y1[7:0]; c = x2[7:0]; d = y2[7:0];
        return {a, b, c, d};
    endfunction

    function automatic logic [35:0] cpk(input int re, input int im);
        logic [17:0] a, b;
        a = re[17:0]; b = im[17:0];
        return {a, b};
    endfunction

    // Complex product from the textbook formula using plain integer arithmetic.
    function automatic logic [35:0] cmul(input logic [31:0] o);
        int x1, y1, x2, y2;
        x1 = int'($signed(o[31:24]));
        y1 = int'($signed(o[23:16]));
        x2 = int'($signed(o[15:8]));
        y2 = int'($signed(o[7:0]));
        return cpk(x1 * x2 - y1 * y2, x1 * y2 + y1 * x2);
    endfunction

    task automatic cyc(input logic pv, input logic pr, input logic [31:0] od,
                       input logic rv, input logic rr, input logic [35:0] rd, input logic swr);
        @(negedge clk);
        op_val = pv; op_rdy = pr; op_data = od;
        res_val = rv; res_rdy = rr; res_data = rd;
        sw_rst = swr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 36'h0, 1'b0);
    endtask

    task automatic push_op(input logic [31:0] od);
        cyc(1'b1, 1'b1, od, 1'b0, 1'b0, 36'h0, 1'b0);
    endtask

    task automatic pop_res(input logic [35:0] rd);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, rd, 1'b0);
    endtask

    task automatic swr();
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 36'h0, 1'b1);
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [31:0] mq[$];
    logic        m_pend;
    logic [35:0] m_pgot, m_pexp;
    int          m_pass, m_err;
    logic        m_ovf, m_unf, m_halt, m_have;
    logic [35:0] m_fgot, m_fexp;

    task automatic model_reset();
        mq.delete();
        m_pend = 1'b0; m_pgot = '0; m_pexp = '0;
        m_pass = 0; m_err = 0;
        m_ovf = 1'b0; m_unf = 1'b0; m_halt = 1'b0; m_have = 1'b0;
        m_fgot = '0; m_fexp = '0;
    endtask

    // One clock edge: report the compare taken last edge, then pop (before push), then push.
    task automatic model_step(input logic psh, input logic pp, input logic [31:0] od,
                              input logic [35:0] rd, input logic s);
        if (s) begin
            model_reset();
            return;
        end
        if (m_pend && !m_halt) begin
            if (m_pgot != m_pexp) begin
                if (m_err < CMAX) m_err++;
                if (!m_have) begin
                    m_have = 1'b1; m_fgot = m_pgot; m_fexp = m_pexp;
                end
                m_halt = 1'b1;
            end else if (m_pass < CMAX) begin
                m_pass++;
            end
        end
        m_pend = 1'b0;
        if (pp) begin
            if (mq.size() == 0) begin
                m_unf = 1'b1;
            end else begin
                m_pend = 1'b1;
                m_pexp = cmul(mq.pop_front());
                m_pgot = rd;
            end
        end
        if (psh) begin
            if (mq.size() == DEPTH) m_ovf = 1'b1;
            else mq.push_back(od);
        end
    endtask

    task automatic model_check();
        check("rnd chk_valid", chk_valid, m_pend && !m_halt);
        check("rnd chk_err",   chk_err, m_pend && !m_halt && (m_pgot != m_pexp));
        check("rnd pass_cnt",  pass_cnt, m_pass);
        check("rnd err_cnt",   err_cnt, m_err);
        check("rnd q_level",   q_level, mq.size());
        check("rnd ovf",       ovf, m_ovf);
        check("rnd unf",       unf, m_unf);
        check("rnd halted",    halted, m_halt);
        check("rnd first_got", first_got, m_fgot);
        check("rnd first_exp", first_exp, m_fexp);
    endtask

    typedef struct {
        logic [31:0] ops;
        logic [35:0] res;
        logic        err;
        logic [35:0] exp;
    } vec_t;

    vec_t tv[8];

    initial begin
        logic [31:0] od, a_ops;
        logic [35:0] rd;
        logic pv, pr, rv, rr, s;
        int wrong_pct;

        rst = 1'b1; sw_rst = 1'b0;
        op_val = 0; op_rdy = 0; op_data = '0;
        res_val = 0; res_rdy = 0; res_data = '0;
        a_ops = opk(3, 4, 2, -1);

        tv[0] = '{a_ops,                   cpk(10, 5),      1'b0, cpk(10, 5)};
        tv[1] = '{opk(-128,-128,-128,-128), cpk(0, 32768),  1'b0, cpk(0, 32768)};
        tv[2] = '{opk(127, 127, 127, 127),  cpk(0, 32258),  1'b0, cpk(0, 32258)};
        tv[3] = '{opk(-128, 0, 127, 0),     cpk(-16256, 0), 1'b0, cpk(-16256, 0)};
        tv[4] = '{opk(-128,127,-128,-128),  cpk(32640, 128), 1'b0, cpk(32640, 128)};
        tv[5] = '{opk(-1, -1, 1, 1),        cpk(0, -2),     1'b0, cpk(0, -2)};
        tv[6] = '{a_ops,                    cpk(10, 6),     1'b1, cpk(10, 5)};
        tv[7] = '{opk(-128,-128,-128,-128), cpk(0, -32768), 1'b1, cpk(0, 32768)};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset chk_valid", chk_valid, 0);
        check("reset q_level", q_level, 0);
        check("reset pass_cnt", pass_cnt, 0);
        check("reset halted", halted, 0);
        check("reset first_got", first_got, 0);
        @(negedge clk);
        rst = 1'b0;

        // Table: one push, one pop, check the pulse and then the counters.
        for (int i = 0; i < 8; i++) begin
            swr();
            push_op(tv[i].ops);
            pop_res(tv[i].res);
            check($sformatf("tv%0d chk_valid", i), chk_valid, 1);
            check($sformatf("tv%0d chk_err", i), chk_err, tv[i].err);
            idle();
            check($sformatf("tv%0d chk_valid_off", i), chk_valid, 0);
            check($sformatf("tv%0d pass_cnt", i), pass_cnt, !tv[i].err);
            check($sformatf("tv%0d err_cnt", i), err_cnt, tv[i].err);
            check($sformatf("tv%0d halted", i), halted, tv[i].err);
            if (tv[i].err) begin
                check($sformatf("tv%0d first_got", i), first_got, tv[i].res);
                check($sformatf("tv%0d first_exp", i), first_exp, tv[i].exp);
            end
        end

        // Stop on error, then no further reporting.
        swr();
        push_op(a_ops);
        pop_res(cpk(10, 6));
        check("halt chk_err", chk_err, 1);
        check("halt halted_early", halted, 0);
        idle();
        check("halt err_cnt", err_cnt, 1);
        check("halt first_got", first_got, cpk(10, 6));
        check("halt first_exp", first_exp, cpk(10, 5));
        check("halt halted", halted, 1);
        push_op(a_ops);
        pop_res(cpk(10, 6));
        check("halt no_chk_valid", chk_valid, 0);
        idle();
        check("halt err_cnt_hold", err_cnt, 1);
        check("halt first_got_hold", first_got, cpk(10, 6));
        check("halt q_level", q_level, 0);

        // Underflow while halted, then software reset clears everything.
        pop_res(cpk(10, 5));
        check("unf flag", unf, 1);
        idle();
        check("unf no_chk_valid", chk_valid, 0);
        swr();
        check("swr unf", unf, 0);
        check("swr halted", halted, 0);
        check("swr err_cnt", err_cnt, 0);
        check("swr first_got", first_got, 0);
        check("swr q_level", q_level, 0);

        // Overflow at DEPTH, push+pop at full, then back-to-back drain.
        for (int i = 0; i < 5; i++) begin
            push_op(a_ops);
            if (i == 3) check("ovf before", ovf, 0);
        end
        check("ovf flag", ovf, 1);
        check("ovf q_level", q_level, 4);
        cyc(1'b1, 1'b1, a_ops, 1'b1, 1'b1, cpk(10, 5), 1'b0);
        check("full pushpop q_level", q_level, 4);
        check("full pushpop chk_valid", chk_valid, 1);
        for (int i = 0; i < 4; i++) begin
            pop_res(cpk(10, 5));
            check($sformatf("drain%0d chk_valid", i), chk_valid, 1);
        end
        idle();
        check("drain pass_cnt", pass_cnt, 5);
        check("drain q_level", q_level, 0);
        check("drain unf", unf, 0);

        // Asynchronous reset with entries queued.
        swr();
        pop_res(36'h0);
        push_op(a_ops);
        pop_res(cpk(10, 5));
        idle();
        push_op(a_ops); push_op(a_ops); push_op(a_ops);
        check("arst pre q_level", q_level, 3);
        check("arst pre pass_cnt", pass_cnt, 1);
        @(negedge clk);
        op_val = 0; op_rdy = 0; res_val = 0; res_rdy = 0;
        #2 rst = 1'b1;
        #1;
        check("arst q_level", q_level, 0);
        check("arst pass_cnt", pass_cnt, 0);
        check("arst unf", unf, 0);
        check("arst chk_valid", chk_valid, 0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic against the transaction-level model.
        model_reset();
        for (int ph = 0; ph < 4; ph++) begin
            wrong_pct = (ph % 2 == 0) ? 0 : 3;
            swr();
            model_reset();
            for (int c = 0; c < 500; c++) begin
                pv = ($urandom_range(0, 3) != 0);
                pr = ($urandom_range(0, 3) != 0);
                rv = ($urandom_range(0, 3) != 0);
                rr = ($urandom_range(0, 3) != 0);
                s  = ($urandom_range(0, 99) == 0);
                od = ($urandom_range(0, 7) == 0) ? 32'h80808080 : $urandom;
                if (mq.size() > 0 && $urandom_range(0, 99) >= wrong_pct) rd = cmul(mq[0]);
                else rd = {4'($urandom), $urandom};
                cyc(pv, pr, od, rv, rr, rd, s);
                model_step(pv & pr, rv & rr, od, rd, s);
                model_check();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/comp_mult_checker.md
COMP_MULT_CHECKER -- requirements
Module: comp_mult_checker

Interface
REQ-001 Parameter DWIDTH, 8, operand component width (signed two's complement).
REQ-002 Parameter DEPTH, 16, operand queue depth; power of two, 2..256.
REQ-003 Parameter CWIDTH, 16, width of pass/error counters.
REQ-004 Parameter STOP_ON_ERR, 1; 1 = halt checking on first mismatch, 0 = continue.
REQ-005 clk  in  1  system clock; all state updates on rising edge.
REQ-006 rst  in  1  hardware reset, asynchronous, active-high.
REQ-007 sw_rst  in  1  software reset, synchronous, active-high.
REQ-008 op_val, op_rdy  in  1 each  operand handshake observed on the DUT input side.
REQ-009 op_data  in  4*DWIDTH  operands {x1, y1, x2, y2}, x1 in the MSBs.
REQ-010 res_val, res_rdy  in  1 each  result handshake observed on the DUT output side.
REQ-011 res_data  in  4*(DWIDTH+1)  DUT result {xr, yr}, each 2*(DWIDTH+1) bits signed.
REQ-012 chk_valid  out  1  one-cycle pulse: a comparison completed.
REQ-013 chk_err  out  1  one-cycle pulse, coincident with chk_valid: that comparison mismatched.
REQ-014 pass_cnt, err_cnt  out  CWIDTH each  saturating match/mismatch counters.
REQ-015 q_level  out  $clog2(DEPTH)+1  current queue occupancy.
REQ-016 ovf, unf, halted  out  1 each  sticky flags: queue overflow, queue underflow, checker halted.
REQ-017 first_got, first_exp  out  4*(DWIDTH+1) each  DUT result and expected result of the first mismatch.

Function
REQ-018 An operand push occurs on a cycle with op_val & op_rdy; a result pop occurs on a cycle with res_val & res_rdy.
REQ-019 The queue is a circular FIFO of DEPTH entries; read and write pointers wrap modulo DEPTH.
REQ-020 A push to a full queue with no pop on the same cycle is dropped, sets ovf, and leaves q_level unchanged.
REQ-021 A push and a pop on the same cycle with the queue full are both accepted; q_level is unchanged.
REQ-022 A pop with the queue empty sets unf, performs no comparison, and produces no chk_valid; there is no bypass of a same-cycle push.
REQ-023 Expected values: xr = x1*x2 - y1*y2 and yr = x1*y2 + y1*x2, computed signed and sign-extended to 2*(DWIDTH+1) bits; the result is exact for all inputs.
REQ-024 Compare pipeline: pop in cycle N; queue head and res_data are registered at N; chk_valid and chk_err assert in cycle N+1; counters and first_* registers update at the end of N+1.
REQ-025 Back-to-back pops each yield one chk_valid, giving a throughput of one compare per cycle.
REQ-026 A mismatch is any bit difference in xr or yr.
REQ-027 The FSM has two states, CHECK and HALT; the reset state is CHECK.
REQ-028 CHECK to HALT: a mismatch occurs while STOP_ON_ERR = 1; halted = 1 in the cycle after the chk_err pulse.
REQ-029 HALT to CHECK: only via sw_rst or rst.
REQ-030 In HALT, pushes and pops still move the queue pointers; no further chk_valid pulses, counter updates or first_* updates occur.
REQ-031 first_got and first_exp load only on the first mismatch since reset and hold thereafter.
REQ-032 pass_cnt and err_cnt saturate at all-ones.

Reset
REQ-033 On rst (asynchronous), all pointers, q_level, counters, flags, first_* registers and pipeline valid bits go to 0, and the FSM goes to CHECK.
REQ-034 sw_rst has the same effect synchronously and takes priority over a push or pop in the same cycle; an in-flight compare is discarded, with no chk_valid pulse.
REQ-035 Queue storage contents are not reset.

Structure
REQ-036 The package comp_mult_pkg holds the FSM state typedef (CHECK/HALT) and localparams for component and result widths derived from DWIDTH.
REQ-037 The one sub-module is comp_mult_fifo (parametrised DEPTH/WIDTH, with full, empty and level outputs); the compare logic and FSM are in the top level.

Verification (DWIDTH=8, DEPTH=4)
REQ-038 Push (3+4i),(2-1i); pop with res (10+5i) -> one cycle later chk_valid=1, chk_err=0, pass_cnt=1.
REQ-039 Push (-128-128i),(-128-128i); pop with res (0+32768i) -> pass; the 18-bit extreme is verified.
REQ-040 STOP_ON_ERR=1: push (3+4i),(2-1i); pop with res (10+6i) -> chk_err=1, err_cnt=1, first_got=(10+6i), first_exp=(10+5i), halted=1; the next pop yields no chk_valid.
REQ-041 Five pushes with no pops -> the fifth push is dropped, ovf=1, q_level=4; then a simultaneous push+pop at full -> q_level stays 4.
REQ-042 Pop with the queue empty -> unf=1, no chk_valid; then sw_rst -> all flags, counters and q_level read 0, and the FSM is in CHECK.
REQ-043 rst asserted mid-stream with 3 entries queued -> all outputs read 0 immediately, without waiting for a clock edge.
